// File: rtl/lsu_data_port.sv
// Load/store data port for the memory stage.
// Issues aligned valid/ready memory requests with byte enables and
// lane-shifted store data, remembers outstanding loads in a small pending
// FIFO, and returns aligned, extended load results one cycle after each
// in-order read response.
//
// Handshake: a request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high. mem_req_valid never depends on
// mem_req_ready. While stalled, the pipeline holds every cmd_* field stable,
// so the request stays stable until it is accepted.
module lsu_data_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int PEND_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_Q103H,
  input  logic                cmd_rd_en_Q103H,
  input  logic                cmd_wr_en_Q103H,
  input  logic [1:0]          cmd_size_Q103H,
  input  logic                cmd_unsigned_Q103H,
  input  logic [ADDR_W-1:0]   cmd_addr_Q103H,
  input  logic [DATA_W-1:0]   cmd_wr_data_Q103H,
  input  logic [4:0]          cmd_rd_Q103H,
  output logic                stall_Q103H,
  output logic                misalign_Q103H,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wr_data,
  output logic [DATA_W/8-1:0] mem_req_byte_en,
  output logic                mem_req_wr_en,
  output logic                mem_req_rd_en,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                ld_valid_Q104H,
  output logic [DATA_W-1:0]   ld_data_Q104H,
  output logic [4:0]          ld_rd_Q104H,
  output logic                rsp_unexpected
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CNT_W = $clog2(PEND_DEPTH + 1);

  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] align_mask;
  logic             size_bad;
  logic             misaligned;
  logic             cmd_mem;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic [NB-1:0]    byte_en_c;

  // Pending load FIFO: one entry per accepted load, popped per response.
  logic [OFF_W-1:0] fifo_off  [PEND_DEPTH];
  logic [1:0]       fifo_size [PEND_DEPTH];
  logic             fifo_uns  [PEND_DEPTH];
  logic [4:0]       fifo_rd   [PEND_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [OFF_W-1:0]  head_off;
  logic [1:0]        head_size;
  logic              head_uns;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext_data;

  assign off = cmd_addr_Q103H[OFF_W-1:0];

  // Pointer advance that wraps at PEND_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PEND_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Alignment check: the offset must be a multiple of the access size;
  // doubles exist only on a 64-bit bus, and load+store at once is illegal.
  always_comb begin
    align_mask = '0;
    size_bad   = 1'b0;
    case (cmd_size_Q103H)
      2'd0: align_mask = '0;
      2'd1: align_mask = OFF_W'(1);
      2'd2: align_mask = OFF_W'(3);
      default: begin
        align_mask = OFF_W'(7);
        size_bad   = (DATA_W != 64);
      end
    endcase
    misaligned = size_bad || ((off & align_mask) != '0) ||
                 (cmd_rd_en_Q103H && cmd_wr_en_Q103H);
  end

  assign cmd_mem    = cmd_valid_Q103H && (cmd_rd_en_Q103H || cmd_wr_en_Q103H);
  assign fifo_full  = (count == CNT_W'(PEND_DEPTH));
  assign fifo_empty = (count == '0);

  // A full FIFO blocks loads even if a response pops in the same cycle.
  assign mem_req_valid  = cmd_mem && !misaligned && !(cmd_rd_en_Q103H && fifo_full);
  assign accept         = mem_req_valid && mem_req_ready;
  assign stall_Q103H    = cmd_mem && !misaligned && !accept;
  assign misalign_Q103H = cmd_mem && misaligned;
  assign push           = accept && cmd_rd_en_Q103H;
  assign pop            = mem_rsp_valid && !fifo_empty;

  // Byte enables: 2^size consecutive lanes starting at the byte offset.
  always_comb begin
    int nbytes;
    nbytes    = 1 << cmd_size_Q103H;
    byte_en_c = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(off)) && (i < int'(off) + nbytes)) begin
        byte_en_c[i] = 1'b1;
      end
    end
  end

  // Request fields read zero when no command is present.
  always_comb begin
    mem_req_addr    = '0;
    mem_req_wr_data = '0;
    mem_req_byte_en = '0;
    mem_req_wr_en   = 1'b0;
    mem_req_rd_en   = 1'b0;
    if (cmd_valid_Q103H) begin
      mem_req_addr    = {cmd_addr_Q103H[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      mem_req_wr_data = cmd_wr_data_Q103H << {off, 3'b000};
      mem_req_byte_en = byte_en_c;
      mem_req_wr_en   = cmd_wr_en_Q103H;
      mem_req_rd_en   = cmd_rd_en_Q103H;
    end
  end

  // FIFO storage writes; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_off[wr_ptr]  <= off;
      fifo_size[wr_ptr] <= cmd_size_Q103H;
      fifo_uns[wr_ptr]  <= cmd_unsigned_Q103H;
      fifo_rd[wr_ptr]   <= cmd_rd_Q103H;
    end
  end

  assign head_off  = fifo_off[rd_ptr];
  assign head_size = fifo_size[rd_ptr];
  assign head_uns  = fifo_uns[rd_ptr];
  assign head_rd   = fifo_rd[rd_ptr];

  // Load alignment and extension for the FIFO head.
  always_comb begin
    int   nbits;
    logic sign_bit;
    nbits    = 8 << head_size;
    shifted  = mem_rsp_data >> {head_off, 3'b000};
    sign_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) sign_bit = shifted[i] && !head_uns;
    end
    ext_data = shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) ext_data[i] = sign_bit;
    end
  end

  // FIFO pointers/count, registered load results and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ld_valid_Q104H <= 1'b0;
      ld_data_Q104H  <= '0;
      ld_rd_Q104H    <= '0;
      rsp_unexpected <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      ld_valid_Q104H <= pop;
      if (pop) begin
        ld_data_Q104H <= ext_data;
        ld_rd_Q104H   <= head_rd;
      end
      if (mem_rsp_valid && fifo_empty) rsp_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port (DATA_W=32, PEND_DEPTH=2): a table of issue-path
// vectors plus hand-written load/response sequences.
module tb_lsu_data_port;

  logic        clk;
  logic        rst;
  logic        cmd_valid_Q103H;
  logic        cmd_rd_en_Q103H;
  logic        cmd_wr_en_Q103H;
  logic [1:0]  cmd_size_Q103H;
  logic        cmd_unsigned_Q103H;
  logic [31:0] cmd_addr_Q103H;
  logic [31:0] cmd_wr_data_Q103H;
  logic [4:0]  cmd_rd_Q103H;
  logic        stall_Q103H;
  logic        misalign_Q103H;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wr_data;
  logic [3:0]  mem_req_byte_en;
  logic        mem_req_wr_en;
  logic        mem_req_rd_en;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        ld_valid_Q104H;
  logic [31:0] ld_data_Q104H;
  logic [4:0]  ld_rd_Q104H;
  logic        rsp_unexpected;

  int checks;
  int failures;

  // Expected load results in issue order: {rd, data}.
  logic [36:0] exp_q[$];

  typedef struct {
    logic        v;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        e_valid;
    logic        e_stall;
    logic        e_mis;
    logic        chk;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wr;
    logic        e_rd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  lsu_data_port #(.DATA_W(32), .ADDR_W(32), .PEND_DEPTH(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid_Q103H    (cmd_valid_Q103H),
    .cmd_rd_en_Q103H    (cmd_rd_en_Q103H),
    .cmd_wr_en_Q103H    (cmd_wr_en_Q103H),
    .cmd_size_Q103H     (cmd_size_Q103H),
    .cmd_unsigned_Q103H (cmd_unsigned_Q103H),
    .cmd_addr_Q103H     (cmd_addr_Q103H),
    .cmd_wr_data_Q103H  (cmd_wr_data_Q103H),
    .cmd_rd_Q103H       (cmd_rd_Q103H),
    .stall_Q103H        (stall_Q103H),
    .misalign_Q103H     (misalign_Q103H),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_wr_data    (mem_req_wr_data),
    .mem_req_byte_en    (mem_req_byte_en),
    .mem_req_wr_en      (mem_req_wr_en),
    .mem_req_rd_en      (mem_req_rd_en),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_data       (mem_rsp_data),
    .ld_valid_Q104H     (ld_valid_Q104H),
    .ld_data_Q104H      (ld_data_Q104H),
    .ld_rd_Q104H        (ld_rd_Q104H),
    .rsp_unexpected     (rsp_unexpected)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver: one load, accepted at the next rising edge (ready held high).
  task automatic issue_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                            input logic [4:0] rd, input logic [31:0] exp_data);
    @(negedge clk);
    cmd_valid_Q103H    = 1'b1;
    cmd_rd_en_Q103H    = 1'b1;
    cmd_wr_en_Q103H    = 1'b0;
    cmd_size_Q103H     = sz;
    cmd_unsigned_Q103H = u;
    cmd_addr_Q103H     = a;
    cmd_wr_data_Q103H  = 32'h0;
    cmd_rd_Q103H       = rd;
    #1;
    chk("ld_issue_valid", 32'(mem_req_valid), 32'd1);
    chk("ld_issue_stall", 32'(stall_Q103H), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid_Q103H = 1'b0;
    exp_q.push_back({rd, exp_data});
  endtask

  // Scoreboard: compare the registered load result with the queue head.
  task automatic check_result();
    logic [36:0] e;
    chk("ld_valid", 32'(ld_valid_Q104H), 32'd1);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("ld_rd", 32'(ld_rd_Q104H), 32'(e[36:32]));
      chk("ld_data", ld_data_Q104H, e[31:0]);
    end
  endtask

  // Driver: a single response cycle, then the result check.
  task automatic send_rsp(input logic [31:0] d);
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_result();
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            v     rd    wr    sz     u     addr          wdata          rdy  | valid stall mis  chk   addr          be     wdata          wr    rd
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'h0000_0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 4'hC, 32'h1234_0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 4'h8, 32'hAB00_0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          4'h0, 32'h0,          1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          4'h0, 32'h0,          1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          4'h0, 32'h0,          1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          4'h0, 32'h0,          1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,          4'h0, 32'h0,          1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          4'h0, 32'h0,          1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0106, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 4'hC, 32'h0000_0000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h1234_56CD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 4'h2, 32'h3456_CD00, 1'b1, 1'b0};

    rst                = 1'b1;
    cmd_valid_Q103H    = 1'b0;
    cmd_rd_en_Q103H    = 1'b0;
    cmd_wr_en_Q103H    = 1'b0;
    cmd_size_Q103H     = 2'd0;
    cmd_unsigned_Q103H = 1'b0;
    cmd_addr_Q103H     = 32'h0;
    cmd_wr_data_Q103H  = 32'h0;
    cmd_rd_Q103H       = 5'd0;
    mem_req_ready      = 1'b1;
    mem_rsp_valid      = 1'b0;
    mem_rsp_data       = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ld_valid", 32'(ld_valid_Q104H), 32'd0);
    chk("rst_ld_data", ld_data_Q104H, 32'h0);
    chk("rst_ld_rd", 32'(ld_rd_Q104H), 32'd0);
    chk("rst_unexpected", 32'(rsp_unexpected), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    rst = 1'b0;

    // Issue-path vectors; the command is withdrawn before each rising edge
    // so nothing is accepted and the FIFO stays empty.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cmd_valid_Q103H    = vecs[i].v;
      cmd_rd_en_Q103H    = vecs[i].rd;
      cmd_wr_en_Q103H    = vecs[i].wr;
      cmd_size_Q103H     = vecs[i].size;
      cmd_unsigned_Q103H = vecs[i].uns;
      cmd_addr_Q103H     = vecs[i].addr;
      cmd_wr_data_Q103H  = vecs[i].wdata;
      mem_req_ready      = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_stall", i), 32'(stall_Q103H), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_misalign", i), 32'(misalign_Q103H), 32'(vecs[i].e_mis));
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].e_addr);
        chk($sformatf("vec%0d_byte_en", i), 32'(mem_req_byte_en), 32'(vecs[i].e_be));
        chk($sformatf("vec%0d_wr_data", i), mem_req_wr_data, vecs[i].e_wdata);
        chk($sformatf("vec%0d_wr_en", i), 32'(mem_req_wr_en), 32'(vecs[i].e_wr));
        chk($sformatf("vec%0d_rd_en", i), 32'(mem_req_rd_en), 32'(vecs[i].e_rd));
      end
      cmd_valid_Q103H = 1'b0;
      mem_req_ready   = 1'b1;
    end

    // Single loads with alignment and extension
    issue_load(32'h100, 2'd2, 1'b0, 5'd5, 32'hDEAD_BEEF);
    send_rsp(32'hDEAD_BEEF);
    @(negedge clk);
    chk("ld_valid_drop", 32'(ld_valid_Q104H), 32'd0);
    issue_load(32'h103, 2'd0, 1'b0, 5'd7, 32'hFFFF_FF80);
    send_rsp(32'h8000_0000);
    issue_load(32'h103, 2'd0, 1'b1, 5'd8, 32'h0000_0080);
    send_rsp(32'h8000_0000);
    issue_load(32'h102, 2'd1, 1'b0, 5'd10, 32'hFFFF_8001);
    send_rsp(32'h8001_0000);

    // Full FIFO: third load blocked even while a response pops
    issue_load(32'h100, 2'd2, 1'b0, 5'd1, 32'h1111_1111);
    issue_load(32'h104, 2'd2, 1'b0, 5'd2, 32'h2222_2222);
    @(negedge clk);
    cmd_valid_Q103H = 1'b1;
    cmd_rd_en_Q103H = 1'b1;
    cmd_wr_en_Q103H = 1'b0;
    cmd_size_Q103H  = 2'd2;
    cmd_unsigned_Q103H = 1'b0;
    cmd_addr_Q103H  = 32'h108;
    cmd_rd_Q103H    = 5'd3;
    mem_rsp_valid   = 1'b1;
    mem_rsp_data    = 32'h1111_1111;
    #1;
    chk("full_stall", 32'(stall_Q103H), 32'd1);
    chk("full_req_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_result();
    chk("after_pop_req_valid", 32'(mem_req_valid), 32'd1);
    chk("after_pop_stall", 32'(stall_Q103H), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid_Q103H = 1'b0;
    exp_q.push_back({5'd3, 32'h3333_3333});
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h2222_2222;
    @(posedge clk);
    #1;
    mem_rsp_data  = 32'h3333_3333;
    @(negedge clk);
    check_result();
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_result();
    @(negedge clk);
    chk("b2b_valid_drop", 32'(ld_valid_Q104H), 32'd0);

    // Simultaneous push and pop with one load pending
    issue_load(32'h110, 2'd2, 1'b0, 5'd11, 32'hAAAA_0001);
    @(negedge clk);
    cmd_valid_Q103H = 1'b1;
    cmd_rd_en_Q103H = 1'b1;
    cmd_addr_Q103H  = 32'h115;
    cmd_size_Q103H  = 2'd0;
    cmd_unsigned_Q103H = 1'b1;
    cmd_rd_Q103H    = 5'd12;
    mem_rsp_valid   = 1'b1;
    mem_rsp_data    = 32'hAAAA_0001;
    #1;
    chk("pushpop_req_valid", 32'(mem_req_valid), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid_Q103H = 1'b0;
    mem_rsp_valid   = 1'b0;
    exp_q.push_back({5'd12, 32'h0000_00C3});
    @(negedge clk);
    check_result();
    send_rsp(32'h0000_C300);

    // Response with empty FIFO
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0BAD;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("unexp_set", 32'(rsp_unexpected), 32'd1);
    chk("unexp_no_ld", 32'(ld_valid_Q104H), 32'd0);
    repeat (3) @(negedge clk);
    chk("unexp_sticky", 32'(rsp_unexpected), 32'd1);

    // Reset mid-operation discards the pending load
    issue_load(32'h100, 2'd2, 1'b0, 5'd9, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_unexpected", 32'(rsp_unexpected), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rst2_unexp_set", 32'(rsp_unexpected), 32'd1);
    chk("rst2_no_ld", 32'(ld_valid_Q104H), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
